// File: rtl/vpipe_pkg.sv
// Shared definitions for the vpipe instruction issuer: opcode encodings,
// instruction field offsets and the issuer FSM state type.
package vpipe_pkg;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

   localparam int OP_LSB  = 6;
   localparam int RS1_LSB = 4;
   localparam int RS2_LSB = 2;
   localparam int RD_LSB  = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_READBACK,
      ST_DONE
   } issuer_state_t;

   function automatic logic [1:0] inst_op(input logic [7:0] w);
      return w[OP_LSB +: 2];
   endfunction

endpackage

// File: rtl/vpipe_inst_issuer_if.sv
// Bundle between the issuer (slave modport) and its environment (master):
// program load, run control, pipeline inst/debug-read port and readback results.
interface vpipe_inst_issuer_if;
   import vpipe_pkg::*;

   // load_valid/load_ready: a word transfers on a rising clk edge where both are
   // high; load_valid must not depend on load_ready, and load_ready may drop
   // without a word being taken (buffer full or not idle).
   logic          load_valid;
   logic [7:0]    load_inst;
   logic          load_ready;
   logic          go;
   logic          busy;
   logic [7:0]    inst;
   logic [1:0]    dummy_read_rf;
   logic [7:0]    dummy_rf_data;
   logic          rd_valid;
   logic [1:0]    rd_idx;
   logic [7:0]    rd_data;
   logic          done;
   logic [4:0]    issued_cnt;
   issuer_state_t state_dbg;

   modport master (
      output load_valid, load_inst, go, dummy_rf_data,
      input  load_ready, busy, inst, dummy_read_rf, rd_valid, rd_idx, rd_data,
             done, issued_cnt, state_dbg
   );

   modport slave (
      input  load_valid, load_inst, go, dummy_rf_data,
      output load_ready, busy, inst, dummy_read_rf, rd_valid, rd_idx, rd_data,
             done, issued_cnt, state_dbg
   );

endinterface

// File: rtl/vpipe_prog_fifo.sv
// DEPTH x 8 program buffer: synchronous FIFO with occupancy count and a
// synchronous clear that empties it between runs.
module vpipe_prog_fifo #(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          wr_en_i,
   input  logic [7:0]    wr_data_i,
   input  logic          rd_en_i,
   output logic [7:0]    rd_data_o,
   output logic [CW-1:0] count_o
);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr_ok;
   logic          rd_ok;

   always_comb begin
      wr_ok    = wr_en_i && (count_q != CW'(DEPTH));
      rd_ok    = rd_en_i && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (wr_ok && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

endmodule

// File: rtl/vpipe_inst_issuer.sv
// Buffers a program, issues it to the pipeline, drains, then reads back r0..r3.
// Define VPIPE_ISSUER_NOP_PAD_EN to pad every non-NOP word with DRAIN NOPs.
module vpipe_inst_issuer
   import vpipe_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int DRAIN = 3
) (
   input logic               clk,
   input logic               rst,
   vpipe_inst_issuer_if.slave bus
);

   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int CNT_W = (DRAIN > 4) ? $clog2(DRAIN + 1) : 3;

   issuer_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       inst_q, inst_d;
   logic [4:0]       issued_q, issued_d;
   logic             rd_valid_q, rd_valid_d;
   logic [1:0]       rd_idx_q, rd_idx_d;
   logic [7:0]       rd_data_q, rd_data_d;

   logic             fifo_wr, fifo_rd, fifo_clr;
   logic [7:0]       fifo_rd_data;
   logic [CW-1:0]    fifo_count;
   logic             load_ready;
   logic             load_fire;
   logic             word_issue;
   logic             pad_hold;

   vpipe_prog_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (fifo_clr),
      .wr_en_i   (fifo_wr),
      .wr_data_i (bus.load_inst),
      .rd_en_i   (fifo_rd),
      .rd_data_o (fifo_rd_data),
      .count_o   (fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      inst_d     = 8'h00;
      issued_d   = issued_q;
      rd_valid_d = 1'b0;
      rd_idx_d   = rd_idx_q;
      rd_data_d  = rd_data_q;
      fifo_wr    = 1'b0;
      fifo_rd    = 1'b0;
      fifo_clr   = 1'b0;
      word_issue = 1'b0;
      load_ready = (state_q == ST_IDLE) && (fifo_count < CW'(DEPTH));
      load_fire  = bus.load_valid && load_ready;

      unique case (state_q)
         ST_IDLE: begin
            fifo_wr = load_fire;
            if (bus.go) begin
               cnt_d    = '0;
               issued_d = 5'd0;
               // The first word is presented at the go edge so inst shows it next cycle.
               if (fifo_count != '0) begin
                  fifo_rd    = 1'b1;
                  inst_d     = fifo_rd_data;
                  word_issue = 1'b1;
                  issued_d   = 5'd1;
                  state_d    = ST_ISSUE;
               end else if (load_fire) begin
                  fifo_wr    = 1'b0;
                  inst_d     = bus.load_inst;
                  word_issue = 1'b1;
                  issued_d   = 5'd1;
                  state_d    = ST_ISSUE;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_ISSUE: begin
            if (!pad_hold) begin
               if (fifo_count != '0) begin
                  fifo_rd    = 1'b1;
                  inst_d     = fifo_rd_data;
                  word_issue = 1'b1;
                  issued_d   = issued_q + 5'd1;
               end else begin
                  state_d = ST_DRAIN;
                  cnt_d   = '0;
               end
            end
         end
         ST_DRAIN: begin
            if (cnt_q == CNT_W'(DRAIN - 1)) begin
               state_d = ST_READBACK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_READBACK: begin
            // Counts 0..3 sample r0..r3; count 4 lets the last result register out.
            if (cnt_q == CNT_W'(4)) begin
               state_d = ST_DONE;
            end else begin
               rd_valid_d = 1'b1;
               rd_idx_d   = cnt_q[1:0];
               rd_data_d  = bus.dummy_rf_data;
               cnt_d      = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            fifo_clr = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef VPIPE_ISSUER_NOP_PAD_EN
   logic [CNT_W-1:0] pad_q, pad_d;

   always_comb begin
      pad_d = pad_q;
      if (word_issue) pad_d = (inst_op(inst_d) != OP_NOP) ? CNT_W'(DRAIN) : '0;
      else if (pad_q != '0) pad_d = pad_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) pad_q <= '0;
      else     pad_q <= pad_d;
   end

   assign pad_hold = (pad_q != '0);
`else
   logic pad_unused;
   assign pad_unused = word_issue;
   assign pad_hold   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         inst_q     <= 8'h00;
         issued_q   <= 5'd0;
         rd_valid_q <= 1'b0;
         rd_idx_q   <= 2'd0;
         rd_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         inst_q     <= inst_d;
         issued_q   <= issued_d;
         rd_valid_q <= rd_valid_d;
         rd_idx_q   <= rd_idx_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign bus.load_ready    = load_ready;
   assign bus.busy          = (state_q != ST_IDLE);
   assign bus.inst          = inst_q;
   assign bus.dummy_read_rf = (state_q == ST_READBACK) ? cnt_q[1:0] : 2'd0;
   assign bus.rd_valid      = rd_valid_q;
   assign bus.rd_idx        = rd_idx_q;
   assign bus.rd_data       = rd_data_q;
   assign bus.done          = (state_q == ST_DONE);
   assign bus.issued_cnt    = issued_q;
   assign bus.state_dbg     = state_q;

endmodule

// File: doc/vpipe_inst_issuer.md
# vpipe_inst_issuer

Instruction-side driver for the 8-bit simple pipeline (`pipeline_v`). It buffers a short program, issues it to the pipeline's `inst` port one instruction per cycle, and waits for the pipeline to drain. It then reads back r0..r3 through the pipeline's `dummy_read_rf`/`dummy_rf_data` debug port and reports the four values. It is the stimulus-and-readback end that pairs with the per-instruction verification wrappers, and it is used in multi-instruction regressions and on-board bring-up.

## Interface
- `DEPTH`, 8: program buffer entries (power of 2, 2..16).
- `DRAIN`, 3: idle NOP cycles after the last issue, so the final instruction reaches writeback.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  program word offered.
- `load_inst`  in  8  program word.
- `load_ready`  out  1  buffer accepts a word this cycle.
- `go`  in  1  start issuing the buffered program.
- `busy`  out  1  high in every state except IDLE.
- `inst`  out  8  to the pipeline `inst` port; registered.
- `dummy_read_rf`  out  2  to the pipeline register-file read index.
- `dummy_rf_data`  in  8  from the pipeline; combinational read of the register selected by `dummy_read_rf`.
- `rd_valid`  out  1  one readback result is valid.
- `rd_idx`  out  2  register index of the result.
- `rd_data`  out  8  register value.
- `done`  out  1  one-cycle pulse at the end of the sequence.
- `issued_cnt`  out  5  number of program words issued in the current or last run.

## Operation
- Instruction format: `[7:6]` op (00 NOP, 01 ADD, 10 SUB, 11 AND), `[5:4]` rs1, `[3:2]` rs2, `[1:0]` rd.
- FSM states: IDLE → ISSUE → DRAIN → READBACK → DONE → IDLE.
- IDLE
  - `load_ready = (count < DEPTH)`.
  - A word is written when `load_valid && load_ready`.
  - `go` moves the FSM to ISSUE when `count > 0`, and to DRAIN when `count == 0`.
  - `go` and load on the same cycle: the word is accepted, then the FSM moves to ISSUE.
- ISSUE
  - Pops one word per cycle into `inst` and increments `issued_cnt`.
  - After the last pop, moves to DRAIN.
- DRAIN
  - `inst` = 0x00 for `DRAIN` cycles, then moves to READBACK.
- READBACK
  - Drives `dummy_read_rf` = 0, 1, 2, 3 on four consecutive cycles.
  - Each value is sampled into `rd_data` the same cycle it is driven.
- DONE
  - `done` = 1 for one cycle, buffer pointers are cleared, then IDLE.
- Ignored inputs:
  - `go` outside IDLE.
  - `load_valid` outside IDLE (`load_ready` = 0).
- `issued_cnt` clears on the cycle `go` is accepted.
- Reset values: `inst` = 0x00, `dummy_read_rf` = 0, `rd_valid` = 0, `rd_idx` = 0, `rd_data` = 0, `done` = 0, `busy` = 0, `issued_cnt` = 0, `load_ready` = 1, buffer empty, state IDLE.
- `rst` in any state aborts the run to these values on the next cycle. No partial readback is emitted.

## Timing
- `go` accepted at cycle t with N words buffered:
  - `inst` shows word k at cycle t+1+k.
  - DRAIN NOPs at t+1+N .. t+N+DRAIN.
  - `dummy_read_rf` = k at t+1+N+DRAIN+k.
  - `rd_valid`/`rd_idx`/`rd_data` for register k at t+2+N+DRAIN+k.
  - `done` at t+6+N+DRAIN.
- Empty-buffer `go`: same schedule with N = 0.
- Buffer full: `load_ready` falls the cycle after the DEPTH-th write. A write offered while full is dropped and not counted.
- `busy` rises at t+1 and falls the cycle after `done`.

## Configuration
- `VPIPE_ISSUER_NOP_PAD_EN` defined:
  - ISSUE inserts `DRAIN` NOP cycles after every non-NOP word, giving hazard-free issue.
  - Words that are already NOP get no padding.
  - `issued_cnt` counts program words only, not inserted NOPs.
- Undefined: back-to-back issue as in Timing.

## Structure
- `vpipe_pkg`:
  - opcode localparams (`OP_NOP`, `OP_ADD`, `OP_SUB`, `OP_AND`);
  - field offsets;
  - FSM state enum `issuer_state_t`.
- Sub-module `vpipe_prog_fifo`: DEPTH×8 synchronous FIFO with count, `wr_en`/`rd_en`, and a synchronous clear.
- The FSM, drain/readback counter, and output registers live in the top.

## Test plan
- Reset, then `go` with empty buffer → `inst` = 0x00 throughout. Readback idx 0..3 with the pipeline model's reset values. `done` at t+9 with DRAIN = 3. `issued_cnt` = 0.
- Load 0x45 (ADD rs1=r0, rs2=r1, rd=r1), `go` at t → `inst` = 0x45 at t+1, then 0x00. `done` at t+10. r1 readback equals the model's r0+r1.
- Load 9 words with DEPTH = 8 → `load_ready` = 0 after the 8th write, the 9th is dropped. `go` issues exactly 8 words, `issued_cnt` = 8.
- `go` and a `load_valid` pulse during ISSUE → both ignored. `issued_cnt` is unchanged and `done` timing is the same as without them.
- `rst` asserted during READBACK at idx 2 → next cycle `rd_valid` = 0, `busy` = 0, `load_ready` = 1, no `done` pulse.
- With `VPIPE_ISSUER_NOP_PAD_EN`, program {0x45, 0x00, 0x9B} → `inst` sequence 0x45, 00, 00, 00, 0x00, 0x9B, 00, 00, 00, then DRAIN NOPs. `issued_cnt` = 3.
